// File: rtl/alu_operand_stage.sv
// ID/EX operand stage: captures decoded operands, resolves RAW hazards by
// forwarding from EX/MEM/WB, and presents registered ALU inputs under valid/ready.
module alu_operand_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [REG_AW-1:0] id_rs1_addr,
  input  logic [REG_AW-1:0] id_rs2_addr,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [XLEN-1:0]   id_pc,
  input  logic              id_a_sel,
  input  logic              id_b_sel,
  input  logic [3:0]        id_alu_op,
  input  logic [REG_AW-1:0] id_rd_addr,
  input  logic              id_rd_we,
  input  logic              flush,
  input  logic [XLEN-1:0]   ex_alu_result,
  input  logic [REG_AW-1:0] mem_rd_addr,
  input  logic              mem_rd_we,
  input  logic [XLEN-1:0]   mem_result,
  input  logic [REG_AW-1:0] wb_rd_addr,
  input  logic              wb_rd_we,
  input  logic [XLEN-1:0]   wb_result,
  input  logic              ex_ready,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_in_a,
  output logic [XLEN-1:0]   ex_in_b,
  output logic [3:0]        ex_alu_select,
  output logic [REG_AW-1:0] ex_rd_addr,
  output logic              ex_rd_we
);

  localparam logic [3:0] ALU_ADD = 4'b0000;

  logic              valid_q, valid_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [3:0]        op_q, op_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic              we_q, we_d;

  logic              capture;
  logic [XLEN-1:0]   fwd_rs1, fwd_rs2;

  assign id_ready = !valid_q || ex_ready;
  assign capture  = id_valid && id_ready && !flush;

  // Youngest producer wins; x0 is hardwired zero and never forwarded.
  always_comb begin
    fwd_rs1 = id_rs1_data;
    if (id_rs1_addr != '0) begin
      if (valid_q && we_q && (rd_q == id_rs1_addr))
        fwd_rs1 = ex_alu_result;
      else if (mem_rd_we && (mem_rd_addr == id_rs1_addr))
        fwd_rs1 = mem_result;
      else if (wb_rd_we && (wb_rd_addr == id_rs1_addr))
        fwd_rs1 = wb_result;
    end
  end

  always_comb begin
    fwd_rs2 = id_rs2_data;
    if (id_rs2_addr != '0) begin
      if (valid_q && we_q && (rd_q == id_rs2_addr))
        fwd_rs2 = ex_alu_result;
      else if (mem_rd_we && (mem_rd_addr == id_rs2_addr))
        fwd_rs2 = mem_result;
      else if (wb_rd_we && (wb_rd_addr == id_rs2_addr))
        fwd_rs2 = wb_result;
    end
  end

  always_comb begin
    valid_d = valid_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    rd_d    = rd_q;
    we_d    = we_q;
    if (flush) begin
      valid_d = 1'b0;
      we_d    = 1'b0;
    end else if (capture) begin
      valid_d = 1'b1;
      a_d     = id_a_sel ? id_pc  : fwd_rs1;
      b_d     = id_b_sel ? id_imm : fwd_rs2;
      op_d    = id_alu_op;
      rd_d    = id_rd_addr;
      we_d    = id_rd_we;
    end else if (valid_q && ex_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= ALU_ADD;
      rd_q    <= '0;
      we_q    <= 1'b0;
    end else begin
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      we_q    <= we_d;
    end
  end

  assign ex_valid      = valid_q;
  assign ex_in_a       = a_q;
  assign ex_in_b       = b_q;
  assign ex_alu_select = op_q;
  assign ex_rd_addr    = rd_q;
  assign ex_rd_we      = we_q && valid_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: directed vector table, hand-written stall/flush/reset
// sequences, and randomized traffic against a transaction-level occupant model.
module tb_alu_operand_stage;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            id_valid, id_ready;
  logic [AW-1:0]   id_rs1_addr, id_rs2_addr;
  logic [XLEN-1:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
  logic            id_a_sel, id_b_sel;
  logic [3:0]      id_alu_op;
  logic [AW-1:0]   id_rd_addr;
  logic            id_rd_we, flush;
  logic [XLEN-1:0] ex_alu_result;
  logic [AW-1:0]   mem_rd_addr, wb_rd_addr;
  logic            mem_rd_we, wb_rd_we;
  logic [XLEN-1:0] mem_result, wb_result;
  logic            ex_ready, ex_valid;
  logic [XLEN-1:0] ex_in_a, ex_in_b;
  logic [3:0]      ex_alu_select;
  logic [AW-1:0]   ex_rd_addr;
  logic            ex_rd_we;

  always #5 clk = ~clk;

  alu_operand_stage #(.XLEN(XLEN), .REG_AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_pc(id_pc), .id_a_sel(id_a_sel), .id_b_sel(id_b_sel),
    .id_alu_op(id_alu_op), .id_rd_addr(id_rd_addr), .id_rd_we(id_rd_we),
    .flush(flush), .ex_alu_result(ex_alu_result),
    .mem_rd_addr(mem_rd_addr), .mem_rd_we(mem_rd_we), .mem_result(mem_result),
    .wb_rd_addr(wb_rd_addr), .wb_rd_we(wb_rd_we), .wb_result(wb_result),
    .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_in_a(ex_in_a), .ex_in_b(ex_in_b),
    .ex_alu_select(ex_alu_select), .ex_rd_addr(ex_rd_addr), .ex_rd_we(ex_rd_we)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Occupant model: what instruction, if any, sits in front of the ALU.
  logic            m_valid = 1'b0;
  logic [XLEN-1:0] m_a = '0, m_b = '0;
  logic [3:0]      m_op = '0;
  logic [AW-1:0]   m_rd = '0;
  logic            m_we = 1'b0;

  // Producers listed youngest first; first live match with a nonzero index wins.
  function automatic logic [XLEN-1:0] ref_fwd(input logic [AW-1:0] rs, input logic [XLEN-1:0] rf);
    logic            hit [3];
    logic [AW-1:0]   dst [3];
    logic [XLEN-1:0] val [3];
    hit[0] = m_valid && m_we; dst[0] = m_rd;        val[0] = ex_alu_result;
    hit[1] = mem_rd_we;       dst[1] = mem_rd_addr; val[1] = mem_result;
    hit[2] = wb_rd_we;        dst[2] = wb_rd_addr;  val[2] = wb_result;
    if (rs == 0) return rf;
    for (int i = 0; i < 3; i++)
      if (hit[i] && dst[i] == rs) return val[i];
    return rf;
  endfunction

  task automatic idle_inputs();
    id_valid = 0; id_rs1_addr = 0; id_rs2_addr = 0; id_rs1_data = 0; id_rs2_data = 0;
    id_imm = 0; id_pc = 0; id_a_sel = 0; id_b_sel = 0; id_alu_op = 0; id_rd_addr = 0;
    id_rd_we = 0; flush = 0; ex_alu_result = 0; mem_rd_addr = 0; mem_rd_we = 0;
    mem_result = 0; wb_rd_addr = 0; wb_rd_we = 0; wb_result = 0; ex_ready = 1;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".ex_valid"}, 32'(ex_valid), 32'(m_valid));
    chk({tag, ".ex_in_a"}, ex_in_a, m_a);
    chk({tag, ".ex_in_b"}, ex_in_b, m_b);
    chk({tag, ".ex_alu_select"}, 32'(ex_alu_select), 32'(m_op));
    chk({tag, ".ex_rd_addr"}, 32'(ex_rd_addr), 32'(m_rd));
    chk({tag, ".ex_rd_we"}, 32'(ex_rd_we), 32'(m_valid && m_we));
  endtask

  // One clock with the currently driven inputs; checks id_ready before the edge
  // and every output just after it.
  task automatic step(input string tag);
    logic exp_ready;
    logic [XLEN-1:0] na, nb;
    #1;
    exp_ready = !m_valid || ex_ready;
    chk({tag, ".id_ready"}, 32'(id_ready), 32'(exp_ready));
    na = id_a_sel ? id_pc  : ref_fwd(id_rs1_addr, id_rs1_data);
    nb = id_b_sel ? id_imm : ref_fwd(id_rs2_addr, id_rs2_data);
    @(posedge clk);
    if (flush) begin
      m_valid = 0; m_we = 0;
    end else if (id_valid && exp_ready) begin
      m_valid = 1; m_a = na; m_b = nb; m_op = id_alu_op; m_rd = id_rd_addr; m_we = id_rd_we;
    end else if (m_valid && ex_ready) begin
      m_valid = 0;
    end
    #1;
    check_outputs(tag);
  endtask

  task automatic issue(input logic [AW-1:0] rs1, input logic [XLEN-1:0] d1,
                       input logic [AW-1:0] rs2, input logic [XLEN-1:0] d2,
                       input logic [3:0] op, input logic [AW-1:0] rd, input logic we);
    id_valid = 1; id_rs1_addr = rs1; id_rs1_data = d1; id_rs2_addr = rs2; id_rs2_data = d2;
    id_alu_op = op; id_rd_addr = rd; id_rd_we = we; id_a_sel = 0; id_b_sel = 0;
  endtask

  task automatic reset_now(input string tag);
    @(posedge clk); #2;
    rst_n = 0;
    #1;
    m_valid = 0; m_a = 0; m_b = 0; m_op = 0; m_rd = 0; m_we = 0;
    check_outputs(tag);
    idle_inputs();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [AW-1:0] occ_rd; logic occ_we;
    logic [AW-1:0] rs1, rs2; logic [XLEN-1:0] d1, d2, pc, imm;
    logic a_sel, b_sel;
    logic [XLEN-1:0] ex_res;
    logic [AW-1:0] mem_rd; logic mem_we; logic [XLEN-1:0] mem_res;
    logic [AW-1:0] wb_rd;  logic wb_we;  logic [XLEN-1:0] wb_res;
    logic [XLEN-1:0] exp_a, exp_b;
  } vec_t;

  function automatic vec_t vdef();
    vec_t v;
    v.occ_rd = 0; v.occ_we = 0; v.rs1 = 0; v.rs2 = 0; v.d1 = 0; v.d2 = 0; v.pc = 0;
    v.imm = 0; v.a_sel = 0; v.b_sel = 0; v.ex_res = 0; v.mem_rd = 0; v.mem_we = 0;
    v.mem_res = 0; v.wb_rd = 0; v.wb_we = 0; v.wb_res = 0; v.exp_a = 0; v.exp_b = 0;
    return v;
  endfunction

  vec_t vecs[7];

  initial begin
    vec_t v;
    v = vdef(); v.occ_rd = 3; v.occ_we = 1; v.rs1 = 3; v.rs2 = 4; v.d1 = 'hAA; v.d2 = 'hBB;
    v.ex_res = 'h11; v.mem_rd = 3; v.mem_we = 1; v.mem_res = 'h22; v.wb_rd = 3; v.wb_we = 1;
    v.wb_res = 'h33; v.exp_a = 'h11; v.exp_b = 'hBB; vecs[0] = v;
    v.occ_we = 0; v.exp_a = 'h22; vecs[1] = v;
    v.mem_we = 0; v.exp_a = 'h33; vecs[2] = v;
    v = vdef(); v.occ_rd = 0; v.occ_we = 1; v.rs1 = 1; v.d1 = 'h77; v.rs2 = 0; v.d2 = 0;
    v.ex_res = 'h5555; v.mem_rd = 0; v.mem_we = 1; v.mem_res = 'hDEAD; v.wb_rd = 0;
    v.wb_we = 1; v.wb_res = 'hBEEF; v.exp_a = 'h77; v.exp_b = 0; vecs[3] = v;
    v = vdef(); v.rs1 = 6; v.d1 = 'h1; v.a_sel = 1; v.b_sel = 1; v.pc = 'h100;
    v.imm = 'hFFFFFFFC; v.wb_rd = 6; v.wb_we = 1; v.wb_res = 'h99;
    v.exp_a = 'h100; v.exp_b = 'hFFFFFFFC; vecs[4] = v;
    v = vdef(); v.occ_rd = 7; v.occ_we = 1; v.rs1 = 7; v.rs2 = 8; v.d1 = 'h1; v.d2 = 'h2;
    v.ex_res = 'h55; v.mem_rd = 8; v.mem_we = 1; v.mem_res = 'h44;
    v.exp_a = 'h55; v.exp_b = 'h44; vecs[5] = v;
    v = vdef(); v.occ_rd = 9; v.occ_we = 1; v.rs1 = 2; v.d1 = 'h2; v.rs2 = 9; v.d2 = 'h3;
    v.b_sel = 1; v.imm = 'h123; v.ex_res = 'h66; v.exp_a = 'h2; v.exp_b = 'h123; vecs[6] = v;

    idle_inputs();
    rst_n = 0;
    #12;
    check_outputs("por");
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    // Single ADD op, then asynchronous reset while an occupant is live.
    issue(1, 5, 2, 7, 4'd0, 4, 1);
    step("single");
    chk("single.a_const", ex_in_a, 32'd5);
    chk("single.b_const", ex_in_b, 32'd7);
    issue(3, 9, 4, 9, 4'd5, 6, 1);
    step("pre_rst");
    reset_now("midrst");

    foreach (vecs[i]) begin
      idle_inputs();
      issue(0, 0, 0, 0, 4'd1, vecs[i].occ_rd, vecs[i].occ_we);
      step("vec_occ");
      idle_inputs();
      issue(vecs[i].rs1, vecs[i].d1, vecs[i].rs2, vecs[i].d2, 4'd2, 10, 1);
      id_pc = vecs[i].pc; id_imm = vecs[i].imm; id_a_sel = vecs[i].a_sel; id_b_sel = vecs[i].b_sel;
      ex_alu_result = vecs[i].ex_res;
      mem_rd_addr = vecs[i].mem_rd; mem_rd_we = vecs[i].mem_we; mem_result = vecs[i].mem_res;
      wb_rd_addr = vecs[i].wb_rd; wb_rd_we = vecs[i].wb_we; wb_result = vecs[i].wb_res;
      step($sformatf("vec%0d", i));
      chk($sformatf("vec%0d.a_tbl", i), ex_in_a, vecs[i].exp_a);
      chk($sformatf("vec%0d.b_tbl", i), ex_in_b, vecs[i].exp_b);
    end

    // Stall for three cycles with a pending instruction, then back-to-back traffic.
    idle_inputs();
    issue(1, 'hA1, 2, 'hB1, 4'd3, 5, 1);
    step("stall_load");
    ex_ready = 0;
    issue(1, 'hA2, 2, 'hB2, 4'd4, 6, 1);
    for (int k = 0; k < 3; k++) begin
      step("stall");
      chk("stall.a_frozen", ex_in_a, 32'hA1);
      chk("stall.id_ready_low", 32'(id_ready), 32'd0);
    end
    ex_ready = 1;
    for (int k = 0; k < 4; k++) begin
      issue(1, 32'h200 + 32'(k), 2, 32'h300 + 32'(k), 4'd7, 5'(k + 11), 1);
      step("b2b");
      chk("b2b.valid", 32'(ex_valid), 32'd1);
      chk("b2b.a_const", ex_in_a, 32'h200 + 32'(k));
    end

    // Flush with an occupant present and an incoming instruction.
    ex_ready = 0;
    issue(1, 'hBAD, 2, 'hBAD, 4'd9, 20, 1);
    flush = 1;
    step("flush");
    chk("flush.valid", 32'(ex_valid), 32'd0);
    chk("flush.rd_we", 32'(ex_rd_we), 32'd0);
    chk("flush.no_bad", 32'(ex_in_a == 32'hBAD), 32'd0);
    flush = 0; id_valid = 0;
    step("post_flush");

    // Randomized traffic with narrow register indices to provoke collisions.
    for (int n = 0; n < 400; n++) begin
      id_valid = ($urandom_range(0, 9) < 7);
      id_rs1_addr = 5'($urandom_range(0, 3)); id_rs2_addr = 5'($urandom_range(0, 3));
      id_rs1_data = (id_rs1_addr == 0) ? '0 : $urandom;
      id_rs2_data = (id_rs2_addr == 0) ? '0 : $urandom;
      id_imm = $urandom; id_pc = $urandom;
      id_a_sel = 1'($urandom); id_b_sel = 1'($urandom);
      id_alu_op = 4'($urandom); id_rd_addr = 5'($urandom_range(0, 3)); id_rd_we = 1'($urandom);
      flush = ($urandom_range(0, 9) == 0);
      ex_alu_result = $urandom; mem_result = $urandom; wb_result = $urandom;
      mem_rd_addr = 5'($urandom_range(0, 3)); mem_rd_we = 1'($urandom);
      wb_rd_addr = 5'($urandom_range(0, 3)); wb_rd_we = 1'($urandom);
      ex_ready = ($urandom_range(0, 9) < 7);
      step("rand");
    end

    reset_now("final_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
